// File: rtl/uart_tx_ctrl_if.sv
// Handshake bundle between the host-side transmit request and the UART TX
// sequencing controller. The master side raises tx_start/parity_en; the
// slave (controller) returns the line-select code and PISO strobes.
//
// Handshake: tx_start is a level request that is accepted only in a cycle
// where the controller is idle. The acceptance cycle is marked by piso_load
// being high in that same cycle. tx_busy rises on the following edge and
// stays high until the edge after the tx_done pulse. Requests seen while
// tx_busy is high are ignored, not queued.
interface uart_tx_ctrl_if;
  logic       tx_start;
  logic       parity_en;
  logic [1:0] select;
  logic       piso_load;
  logic       piso_shift;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_start,
    output parity_en,
    input  select,
    input  piso_load,
    input  piso_shift,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_start,
    input  parity_en,
    output select,
    output piso_load,
    output piso_shift,
    output tx_busy,
    output tx_done
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencing controller. Walks START, DATA x DATA_BITS,
// optional PARITY and STOP, each lasting CLKS_PER_BIT cycles, and drives
// the line-select code for the TX mux plus load/shift strobes for the PISO.
// DATA_BITS is expected in 5..9 and CLKS_PER_BIT >= 2.
module uart_tx_ctrl #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_ctrl_if.slave      bus,
  output logic [2:0]         state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_DATA   = 2'b01;
  localparam logic [1:0] SEL_PARITY = 2'b10;
  localparam logic [1:0] SEL_IDLE   = 2'b11;

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  state_t        state_q;
  logic [CW-1:0] baud_q;
  logic [BW-1:0] bit_q;
  logic          par_q;
  logic [1:0]    select_q;
  logic          busy_q;

  logic          bit_end;
  logic          last_bit;

  assign bit_end  = (baud_q == BAUD_LAST);
  assign last_bit = (bit_q == BIT_LAST);

  // Sequencer: state, baud/bit counters, latched parity enable and the
  // registered select/busy outputs all advance together on each edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      par_q    <= 1'b0;
      select_q <= SEL_IDLE;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          baud_q <= '0;
          if (bus.tx_start) begin
            state_q  <= S_START;
            select_q <= SEL_START;
            busy_q   <= 1'b1;
            par_q    <= bus.parity_en;
          end
        end
        S_START: begin
          if (bit_end) begin
            state_q  <= S_DATA;
            select_q <= SEL_DATA;
            baud_q   <= '0;
            bit_q    <= '0;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_q <= '0;
            if (last_bit) begin
              if (par_q) begin
                state_q  <= S_PARITY;
                select_q <= SEL_PARITY;
              end else begin
                state_q  <= S_STOP;
                select_q <= SEL_IDLE;
              end
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            state_q  <= S_STOP;
            select_q <= SEL_IDLE;
            baud_q   <= '0;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            state_q  <= S_IDLE;
            select_q <= SEL_IDLE;
            busy_q   <= 1'b0;
            baud_q   <= '0;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          select_q <= SEL_IDLE;
          busy_q   <= 1'b0;
          baud_q   <= '0;
        end
      endcase
    end
  end

  // Strobes are decoded from registered state so they line up with the
  // acceptance cycle and the bit-end cycle; reset suppresses all of them.
  assign bus.piso_load  = (state_q == S_IDLE) && bus.tx_start && !rst;
  assign bus.piso_shift = (state_q == S_DATA) && bit_end && !rst;
  assign bus.tx_done    = (state_q == S_STOP) && bit_end && !rst;
  assign bus.select     = select_q;
  assign bus.tx_busy    = busy_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl. Two instances (8 data bits / 4 clocks per bit and
// 5 data bits / 2 clocks per bit) share one set of inputs. A frame-position
// model predicts every cycle's outputs for both; a table of directed frames
// measures frame-level properties on one chosen instance.
module tb_uart_tx_ctrl;

  localparam int DB_A  = 8;
  localparam int CPB_A = 4;
  localparam int DB_B  = 5;
  localparam int CPB_B = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_start = 1'b0;
  logic parity_en = 1'b0;
  logic chk_en = 1'b0;
  logic [2:0] state_a;
  logic [2:0] state_b;

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  uart_tx_ctrl_if ifa ();
  uart_tx_ctrl_if ifb ();

  assign ifa.tx_start  = tx_start;
  assign ifa.parity_en = parity_en;
  assign ifb.tx_start  = tx_start;
  assign ifb.parity_en = parity_en;

  uart_tx_ctrl #(.DATA_BITS(DB_A), .CLKS_PER_BIT(CPB_A)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa), .state_o(state_a)
  );
  uart_tx_ctrl #(.DATA_BITS(DB_B), .CLKS_PER_BIT(CPB_B)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb), .state_o(state_b)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [5:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Each instance is either idle or at position pos within a frame of
  // (2 + data bits + parity) bit periods; outputs follow from pos by division.
  bit m_active[2];
  bit m_par[2];
  int m_pos[2];

  function automatic int db_of(int k);
    return (k == 0) ? DB_A : DB_B;
  endfunction

  function automatic int cpb_of(int k);
    return (k == 0) ? CPB_A : CPB_B;
  endfunction

  function automatic int flen(int k);
    return (2 + db_of(k) + (m_par[k] ? 1 : 0)) * cpb_of(k);
  endfunction

  // Expected {select, load, shift, busy, done} for the current cycle.
  function automatic logic [5:0] exp_out(int k, logic st, logic r);
    logic [1:0] s;
    logic ld;
    logic sh;
    logic bz;
    logic dn;
    int b;
    int ph;
    s = 2'b11; ld = 1'b0; sh = 1'b0; bz = 1'b0; dn = 1'b0;
    if (!m_active[k]) begin
      ld = st && !r;
    end else begin
      b  = m_pos[k] / cpb_of(k);
      ph = m_pos[k] % cpb_of(k);
      bz = 1'b1;
      if (b == 0) s = 2'b00;
      else if (b <= db_of(k)) s = 2'b01;
      else if (m_par[k] && b == db_of(k) + 1) s = 2'b10;
      else s = 2'b11;
      sh = (b >= 1) && (b <= db_of(k)) && (ph == cpb_of(k) - 1) && !r;
      dn = (m_pos[k] == flen(k) - 1) && !r;
    end
    return {s, ld, sh, bz, dn};
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_active[k] = 1'b0; m_par[k] = 1'b0; m_pos[k] = 0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_active[k] = 1'b0; m_pos[k] = 0; m_par[k] = 1'b0;
      end else if (!m_active[k]) begin
        if (tx_start) begin
          m_active[k] = 1'b1; m_pos[k] = 0; m_par[k] = parity_en;
        end
      end else if (m_pos[k] == flen(k) - 1) begin
        m_active[k] = 1'b0;
      end else begin
        m_pos[k] = m_pos[k] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      exp_q.push_back(exp_out(0, tx_start, rst));
      exp_q.push_back(exp_out(1, tx_start, rst));
      check("cycle_a", {26'd0, ifa.select, ifa.piso_load, ifa.piso_shift, ifa.tx_busy, ifa.tx_done},
            {26'd0, exp_q.pop_front()});
      check("cycle_b", {26'd0, ifb.select, ifb.piso_load, ifb.piso_shift, ifb.tx_busy, ifb.tx_done},
            {26'd0, exp_q.pop_front()});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic busy_any;
    busy_any = 1'b1;
    tx_start = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 200 && busy_any; i++) begin
      step();
      busy_any = ifa.tx_busy | ifb.tx_busy;
    end
    check("drain_idle", {31'd0, busy_any}, 32'd0);
    step();
    step();
  endtask

  typedef struct {
    int dut;       // 0 = 8/4 instance, 1 = 5/2 instance
    bit par;
    bit hold;      // keep tx_start high through the window
    bit toggle;    // drop parity_en at cycle 10
    int rst_at;    // cycle with rst high, 0 = none
    int exp_busy;
    int exp_shift;
    int exp_par;
    int exp_done;  // first tx_done cycle, 0 = none
    int exp_loads; // loads within cycles 1..50
    int gap;       // expected spacing of shifts in the first frame
  } vec_t;

  task automatic run_vec(input int idx, input vec_t v);
    int busy_n, sh_n, par_n, done_at, loads, gap_bad, last_sh;
    logic [1:0] s;
    logic ld, sh, bz, dn;
    busy_n = 0; sh_n = 0; par_n = 0; done_at = 0; loads = 0; gap_bad = 0; last_sh = -1;
    tx_start = 1'b1;
    parity_en = v.par;
    @(negedge clk);
    ld = (v.dut == 0) ? ifa.piso_load : ifb.piso_load;
    check($sformatf("v%0d_accept_load", idx), {31'd0, ld}, 32'd1);
    for (int c = 1; c <= 50; c++) begin
      step();
      if (!v.hold) tx_start = 1'b0;
      if (v.toggle && c == 10) parity_en = 1'b0;
      rst = (c == v.rst_at);
      @(negedge clk);
      if (v.dut == 0) begin
        s = ifa.select; ld = ifa.piso_load; sh = ifa.piso_shift; bz = ifa.tx_busy; dn = ifa.tx_done;
      end else begin
        s = ifb.select; ld = ifb.piso_load; sh = ifb.piso_shift; bz = ifb.tx_busy; dn = ifb.tx_done;
      end
      if (bz) busy_n++;
      if (s == 2'b10) par_n++;
      if (ld) loads++;
      if (sh) begin
        sh_n++;
        if (last_sh >= 0 && done_at == 0 && (c - last_sh) != v.gap) gap_bad++;
        last_sh = c;
      end
      if (dn && done_at == 0) done_at = c;
    end
    check($sformatf("v%0d_busy_cycles", idx), busy_n, v.exp_busy);
    check($sformatf("v%0d_shift_pulses", idx), sh_n, v.exp_shift);
    check($sformatf("v%0d_parity_cycles", idx), par_n, v.exp_par);
    check($sformatf("v%0d_done_cycle", idx), done_at, v.exp_done);
    check($sformatf("v%0d_extra_loads", idx), loads, v.exp_loads);
    check($sformatf("v%0d_shift_gap_bad", idx), gap_bad, 0);
    drain();
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[7];

  initial begin
    //          dut par hold tog rst busy sh par done lds gap
    vecs[0] = '{0, 1, 0, 0, 0,  44, 8, 4, 44, 0, 4};  // basic frame with parity
    vecs[1] = '{0, 0, 0, 0, 0,  40, 8, 0, 40, 0, 4};  // no parity
    vecs[2] = '{0, 1, 1, 0, 0,  49, 8, 4, 44, 1, 4};  // request held, parity
    vecs[3] = '{0, 0, 1, 0, 0,  49, 9, 0, 40, 1, 4};  // request held, no parity
    vecs[4] = '{0, 1, 0, 0, 18, 18, 3, 0, 0,  0, 4};  // reset during data bit 3
    vecs[5] = '{0, 1, 0, 1, 0,  44, 8, 4, 44, 0, 4};  // full frame after reset; parity_en dropped mid-frame
    vecs[6] = '{1, 1, 0, 0, 0,  16, 5, 2, 16, 0, 2};  // minimum parameters

    rst = 1'b1;
    tx_start = 1'b0;
    parity_en = 1'b0;
    step();
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_select", {30'd0, ifa.select}, 32'd3);
    check("reset_busy", {31'd0, ifa.tx_busy}, 32'd0);
    check("reset_load", {31'd0, ifa.piso_load}, 32'd0);
    check("reset_shift", {31'd0, ifa.piso_shift}, 32'd0);
    check("reset_done", {31'd0, ifa.tx_done}, 32'd0);
    check("reset_select_b", {30'd0, ifb.select}, 32'd3);
    step();
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Randomized traffic, every cycle checked against the model.
    for (int i = 0; i < 3000; i++) begin
      tx_start  = ($urandom_range(0, 9) < 3);
      parity_en = $urandom_range(0, 1) == 1;
      rst       = ($urandom_range(0, 199) == 0);
      step();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
